countdown_ctrl: RTL and testbench

- Sequencing controller for the two-digit BCD countdown timer: tens digit counter plus the ones-digit down counter with borrow.
- Converts one-pulse start/pause and clear buttons into the counters' en, decrease and synchronous-clear (rst_2) controls.
- Detects 00 and runs the end-of-count LED blink.
- Sits between the debounce/one-pulse logic and the digit counters; clocked by the same slow count clock clk_d.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/countdown_ctrl_led_blinker.sv | 29 ++
 rtl/countdown_ctrl.sv | 50 +++++
 tb/tb_countdown_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encodings and constants for the countdown timer controller
package countdown_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    localparam logic LED_ALL_ON = 1'b1;
    localparam logic LED_ALL_OFF = 1'b0;
    localparam logic [3:0] BCD_ZERO = 4'd0;
endpackage

// File: rtl/countdown_ctrl_led_blinker.sv
// led_blinker: end-of-count LED pattern, all on at entry then toggling every BLINK_CYC cycles
module led_blinker
    import countdown_pkg::*;
#(
    parameter int BLINK_CYC = 1,
    parameter int LED_W = 16
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic             active,
    output logic [LED_W-1:0] leds
);
    logic [3:0] blink_cnt;
    logic       on;
    logic       wrap;
    assign wrap = blink_cnt == 4'(BLINK_CYC - 1);
    // active is the state being entered, so !on marks the entry edge
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            leds <= {LED_W{LED_ALL_OFF}};
            blink_cnt <= '0;
            on <= 1'b0;
        end else begin
            on <= active;
            blink_cnt <= (!active || !on || wrap) ? '0 : blink_cnt + 4'd1;
            leds <= !active ? {LED_W{LED_ALL_OFF}} : !on ? {LED_W{LED_ALL_ON}} : wrap ? ~leds : leds;
        end
    end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: start/pause/clear sequencing, 00 detection and end-of-count blink for the BCD timer
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int BLINK_CYC = 1,
    parameter int LED_W = 16
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clear,
    input  logic [3:0]       d1,
    input  logic [3:0]       d0,
    output logic             en,
    output logic             decrease,
    output logic             clr,
    output logic [1:0]       state,
    output logic             done,
    output logic [LED_W-1:0] leds
);
    state_t cur, nxt;
    logic   zero;
    assign zero = d1 == BCD_ZERO && d0 == BCD_ZERO;
    always_comb begin
        nxt = cur;
        if (btn_clear) nxt = S_IDLE;
        else if (cur == S_IDLE && btn_start) nxt = zero ? S_DONE : S_RUN;
        else if (cur == S_RUN) nxt = zero ? S_DONE : (btn_start ? S_PAUSE : S_RUN);
        else if (cur == S_PAUSE && btn_start) nxt = S_RUN;
    end
    always_ff @(posedge clk_d or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
            clr <= 1'b0;
        end else begin
            cur <= nxt;
            clr <= btn_clear;
        end
    end
    assign en = cur == S_RUN;
    assign decrease = !zero;
    assign done = cur == S_DONE;
    assign state = cur;
    led_blinker #(.BLINK_CYC(BLINK_CYC), .LED_W(LED_W)) u_blink (
        .clk_d(clk_d),
        .rst(rst),
        .active(nxt == S_DONE),
        .leds(leds)
    );
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed and random stimulus against a cycle-level reference of the timer controller
module tb_countdown_ctrl;
    localparam int BC = 2;
    localparam int LW = 16;
    logic          clk_d = 1'b0;
    logic          rst = 1'b1;
    logic          btn_start = 1'b0;
    logic          btn_clear = 1'b0;
    logic [3:0]    d1 = 4'd0;
    logic [3:0]    d0 = 4'd0;
    logic          en, decrease, clr, done;
    logic [1:0]    state;
    logic [LW-1:0] leds;
    int checks = 0;
    int errors = 0;
    int m_st = 0;
    int m_age = 0;
    bit m_clr = 1'b0;
    countdown_ctrl #(.BLINK_CYC(BC), .LED_W(LW)) dut (
        .clk_d(clk_d),
        .rst(rst),
        .btn_start(btn_start),
        .btn_clear(btn_clear),
        .d1(d1),
        .d0(d0),
        .en(en),
        .decrease(decrease),
        .clr(clr),
        .state(state),
        .done(done),
        .leds(leds)
    );
    always #5 clk_d = ~clk_d;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int val();
        return int'(d1) * 10 + int'(d0);
    endfunction
    task automatic preset(input int v);
        d1 = 4'(v / 10);
        d0 = 4'(v % 10);
    endtask
    function automatic logic [LW-1:0] exp_leds();
        if (m_st != 3) return '0;
        return ((m_age / BC) % 2 == 0) ? {LW{1'b1}} : '0;
    endfunction
    task automatic compare_all(input string tag);
        check({tag, ".state"}, 32'(state), 32'(m_st));
        check({tag, ".en"}, 32'(en), 32'(m_st == 1));
        check({tag, ".decrease"}, 32'(decrease), 32'(!(d1 == 0 && d0 == 0)));
        check({tag, ".done"}, 32'(done), 32'(m_st == 3));
        check({tag, ".clr"}, 32'(clr), 32'(m_clr));
        check({tag, ".leds"}, 32'(leds), 32'(exp_leds()));
    endtask
    task automatic model_edge(input bit s, input bit c, input bit z);
        int prev;
        prev = m_st;
        m_clr = c;
        if (c) m_st = 0;
        else if (prev == 0 && s) m_st = z ? 3 : 1;
        else if (prev == 1 && z) m_st = 3;
        else if (prev == 1 && s) m_st = 2;
        else if (prev == 2 && s) m_st = 1;
        m_age = (m_st == 3 && prev == 3) ? m_age + 1 : 0;
    endtask
    task automatic step(input bit s, input bit c);
        bit z, e, dc, cl;
        int v;
        btn_start = s;
        btn_clear = c;
        #1;
        e = en;
        dc = decrease;
        cl = clr;
        z = d1 == 0 && d0 == 0;
        @(posedge clk_d);
        model_edge(s, c, z);
        #1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        if (cl) preset(0);
        else if (e && dc && d1 <= 9 && d0 <= 9) begin
            v = val() - 1;
            preset(v);
        end
        #1;
        compare_all("step");
    endtask
    task automatic async_reset();
        rst = 1'b1;
        #1;
        m_st = 0;
        m_age = 0;
        m_clr = 1'b0;
        preset(0);
        #1;
        compare_all("async_rst");
        rst = 1'b0;
        #1;
    endtask
    initial begin
        int v, r;
        #2;
        compare_all("reset");
        #5;
        rst = 1'b0;
        preset(99);
        step(1, 0);
        check("start_hold99", 32'(val()), 32'd99);
        step(0, 0);
        check("first_dec98", 32'(val()), 32'd98);
        preset(75);
        step(1, 0);
        check("paused", 32'(state), 32'd2);
        v = val();
        repeat (10) step(0, 0);
        check("pause_hold", 32'(val()), 32'(v));
        step(1, 0);
        check("resume_hold", 32'(val()), 32'(v));
        step(0, 0);
        check("resume_dec", 32'(val()), 32'(v - 1));
        preset(2);
        repeat (3) step(0, 0);
        check("done_reached", 32'(state), 32'd3);
        check("hold_00", 32'(val()), 32'd0);
        repeat (8) step(0, 0);
        step(1, 0);
        check("done_ignores_start", 32'(state), 32'd3);
        step(0, 1);
        check("clr_pulse", 32'(clr), 32'd1);
        step(0, 0);
        check("clr_one_cycle", 32'(clr), 32'd0);
        preset(42);
        step(1, 0);
        step(1, 1);
        check("clear_wins", 32'(state), 32'd0);
        step(0, 0);
        check("clear_to00", 32'(val()), 32'd0);
        preset(31);
        step(1, 0);
        step(0, 0);
        async_reset();
        preset(0);
        step(1, 0);
        check("zero_start_done", 32'(state), 32'd3);
        step(0, 1);
        step(0, 0);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) preset($urandom_range(0, 12));
            else if (r < 6) preset($urandom_range(0, 99));
            else if (r == 6) begin
                d1 = 4'($urandom_range(0, 1));
                d0 = 4'($urandom_range(10, 15));
            end else if (r == 7) begin
                #1;
                async_reset();
            end
            step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
